// File: rtl/l15_data_ram_banked.sv
// Banked multi-way data store for the L1.5 instruction cache: parallel all-way fetch read,
// single-way byte-masked refill write, same-bank conflicts arbitrated with a read-starvation limit.

module icache_data_sram_wrap #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int BEHAV_MEM  = 1,
    parameter int FPGA_MEM   = 0
) (
    input  logic                  clk,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BE_WIDTH-1:0]   be,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    if (FPGA_MEM != 0 || BEHAV_MEM == 0) begin : g_byte_loop
        always_ff @(posedge clk) begin
            if (req) begin
                if (we) begin
                    for (int i = 0; i < BE_WIDTH; i++) begin
                        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end else begin
                    rdata <= mem[addr];
                end
            end
        end
    end else begin : g_bit_mask
        logic [DATA_WIDTH-1:0] bit_mask;

        always_comb begin
            bit_mask = '0;
            for (int i = 0; i < BE_WIDTH; i++) begin
                bit_mask[i*8 +: 8] = {8{be[i]}};
            end
        end

        always_ff @(posedge clk) begin
            if (req) begin
                if (we) mem[addr] <= (mem[addr] & ~bit_mask) | (wdata & bit_mask);
                else    rdata     <= mem[addr];
            end
        end
    end

endmodule

module l15_data_ram_banked #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 7,
    parameter int NB_WAYS      = 4,
    parameter int NB_BANKS     = 2,
    parameter int BE_WIDTH     = DATA_WIDTH / 8,
    parameter int STARVE_LIMIT = 3,
    parameter int BEHAV_MEM    = 1,
    parameter int FPGA_MEM     = 0,
    localparam int WAY_W       = (NB_WAYS > 1) ? $clog2(NB_WAYS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rd_req_i,
    input  logic [ADDR_WIDTH-1:0]         rd_addr_i,
    output logic                          rd_gnt_o,
    output logic                          rd_rvalid_o,
    output logic [NB_WAYS*DATA_WIDTH-1:0] rd_rdata_o,
    input  logic                          wr_req_i,
    input  logic [ADDR_WIDTH-1:0]         wr_addr_i,
    input  logic [WAY_W-1:0]              wr_way_i,
    input  logic [DATA_WIDTH-1:0]         wr_wdata_i,
    input  logic [BE_WIDTH-1:0]           wr_be_i,
    output logic                          wr_gnt_o
);

    localparam int BANK_BITS = $clog2(NB_BANKS);
    localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int ROW_BITS  = ADDR_WIDTH - BANK_BITS;
    localparam int ROW_W     = (ROW_BITS > 0) ? ROW_BITS : 1;
    localparam int DEPTH     = (2 ** ADDR_WIDTH) / NB_BANKS;
    localparam int CNT_W     = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [BANK_W-1:0] rd_bank, wr_bank, rd_bank_q;
    logic [ROW_W-1:0]  rd_row, wr_row;
    logic [CNT_W-1:0]  starve_cnt;
    logic              conflict, starved, rd_rvalid_q;

    logic [NB_BANKS-1:0][NB_WAYS*DATA_WIDTH-1:0] bank_rdata;
    logic [NB_WAYS*DATA_WIDTH-1:0]               rdata_mux, rdata_hold_q;

    if (BANK_BITS > 0) begin : g_bank_sel
        assign rd_bank = rd_addr_i[BANK_BITS-1:0];
        assign wr_bank = wr_addr_i[BANK_BITS-1:0];
    end else begin : g_single_bank
        assign rd_bank = '0;
        assign wr_bank = '0;
    end

    if (ROW_BITS > 0) begin : g_row_sel
        assign rd_row = rd_addr_i[ADDR_WIDTH-1:BANK_BITS];
        assign wr_row = wr_addr_i[ADDR_WIDTH-1:BANK_BITS];
    end else begin : g_single_row
        assign rd_row = '0;
        assign wr_row = '0;
    end

    // Write wins a same-bank conflict until the read has been denied STARVE_LIMIT times in a row.
    always_comb begin
        conflict = rd_req_i & wr_req_i & (rd_bank == wr_bank);
        starved  = (starve_cnt == CNT_W'(STARVE_LIMIT));
        rd_gnt_o = rd_req_i & (~conflict | starved);
        wr_gnt_o = wr_req_i & (~conflict | ~starved);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (rd_gnt_o) begin
            starve_cnt <= '0;
        end else if (rd_req_i && !starved) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
        for (genvar w = 0; w < NB_WAYS; w++) begin : g_way
            logic wr_sel, rd_sel;

            assign wr_sel = wr_gnt_o & (wr_bank == BANK_W'(b)) & (wr_way_i == WAY_W'(w));
            assign rd_sel = rd_gnt_o & (rd_bank == BANK_W'(b));

            icache_data_sram_wrap #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (ROW_W),
                .DEPTH      (DEPTH),
                .BE_WIDTH   (BE_WIDTH),
                .BEHAV_MEM  (BEHAV_MEM),
                .FPGA_MEM   (FPGA_MEM)
            ) u_sram (
                .clk   (clk),
                .req   (wr_sel | rd_sel),
                .we    (wr_sel),
                .addr  (wr_sel ? wr_row : rd_row),
                .wdata (wr_wdata_i),
                .be    (wr_be_i),
                .rdata (bank_rdata[b][w*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    end

    assign rdata_mux = bank_rdata[rd_bank_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_rvalid_q  <= 1'b0;
            rd_bank_q    <= '0;
            rdata_hold_q <= '0;
        end else begin
            rd_rvalid_q <= rd_gnt_o;
            if (rd_gnt_o)    rd_bank_q    <= rd_bank;
            if (rd_rvalid_q) rdata_hold_q <= rdata_mux;
        end
    end

    // Reset masks an in-flight response in the same cycle it would appear.
    assign rd_rvalid_o = rd_rvalid_q & ~rst;
    assign rd_rdata_o  = rst ? '0 : (rd_rvalid_q ? rdata_mux : rdata_hold_q);

endmodule

// File: tb/tb_l15_data_ram_banked.sv
// Directed self-checking bench for l15_data_ram_banked with default parameters.

module tb_l15_data_ram_banked;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_req_i;
    logic [6:0]   rd_addr_i;
    logic         rd_gnt_o;
    logic         rd_rvalid_o;
    logic [255:0] rd_rdata_o;
    logic         wr_req_i;
    logic [6:0]   wr_addr_i;
    logic [1:0]   wr_way_i;
    logic [63:0]  wr_wdata_i;
    logic [7:0]   wr_be_i;
    logic         wr_gnt_o;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] SET5_FINAL = {64'h0303030303030303, 64'h11223344AAAAAAAA,
                                           64'h0202020202020202, 64'h0101010101010101};

    always #5 clk = ~clk;

    l15_data_ram_banked dut (
        .clk         (clk),
        .rst         (rst),
        .rd_req_i    (rd_req_i),
        .rd_addr_i   (rd_addr_i),
        .rd_gnt_o    (rd_gnt_o),
        .rd_rvalid_o (rd_rvalid_o),
        .rd_rdata_o  (rd_rdata_o),
        .wr_req_i    (wr_req_i),
        .wr_addr_i   (wr_addr_i),
        .wr_way_i    (wr_way_i),
        .wr_wdata_i  (wr_wdata_i),
        .wr_be_i     (wr_be_i),
        .wr_gnt_o    (wr_gnt_o)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [6:0] addr, input logic [1:0] way,
                            input logic [63:0] data, input logic [7:0] be);
        wr_req_i = 1'b1; wr_addr_i = addr; wr_way_i = way; wr_wdata_i = data; wr_be_i = be;
        #1;
        check("wr_gnt_solo", wr_gnt_o, 1);
        tick();
        wr_req_i = 1'b0;
    endtask

    task automatic do_read(input logic [6:0] addr);
        rd_req_i = 1'b1; rd_addr_i = addr;
        #1;
        check("rd_gnt_solo", rd_gnt_o, 1);
        tick();
        rd_req_i = 1'b0;
        check("rd_rvalid", rd_rvalid_o, 1);
    endtask

    initial begin
        rst = 1'b1; rd_req_i = 1'b0; rd_addr_i = '0; wr_req_i = 1'b0;
        wr_addr_i = '0; wr_way_i = '0; wr_wdata_i = '0; wr_be_i = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("reset_rvalid", rd_rvalid_o, 0);
        check("reset_rdata", rd_rdata_o, 0);
        check("reset_starve", dut.starve_cnt, 0);
        check("idle_rd_gnt", rd_gnt_o, 0);
        check("idle_wr_gnt", wr_gnt_o, 0);
        tick();

        // Test 1: full write, read back
        do_write(7'd5, 2'd0, 64'h0101010101010101, 8'hFF);
        do_write(7'd5, 2'd1, 64'h0202020202020202, 8'hFF);
        do_write(7'd5, 2'd3, 64'h0303030303030303, 8'hFF);
        do_write(7'd5, 2'd2, 64'h1122334455667788, 8'hFF);
        do_read(7'd5);
        check("t1_way2", rd_rdata_o[128 +: 64], 64'h1122334455667788);
        check("t1_way0", rd_rdata_o[0 +: 64], 64'h0101010101010101);

        // Test 2: partial byte-enable write
        do_write(7'd5, 2'd2, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        do_read(7'd5);
        check("t2_set5", rd_rdata_o, SET5_FINAL);

        // Test 3: different banks in the same cycle
        do_write(7'd4, 2'd1, 64'h4444444444444444, 8'hFF);
        rd_req_i = 1'b1; rd_addr_i = 7'd4;
        wr_req_i = 1'b1; wr_addr_i = 7'd7; wr_way_i = 2'd0;
        wr_wdata_i = 64'h7777777777777777; wr_be_i = 8'hFF;
        #1;
        check("t3_rd_gnt", rd_gnt_o, 1);
        check("t3_wr_gnt", wr_gnt_o, 1);
        tick();
        rd_req_i = 1'b0; wr_req_i = 1'b0;
        check("t3_rvalid", rd_rvalid_o, 1);
        check("t3_set4_way1", rd_rdata_o[64 +: 64], 64'h4444444444444444);
        do_read(7'd7);
        check("t3_set7_way0", rd_rdata_o[0 +: 64], 64'h7777777777777777);

        // Test 4: same-bank conflict held, starvation limit
        do_write(7'd6, 2'd0, 64'h6666666666666666, 8'hFF);
        rd_req_i = 1'b1; rd_addr_i = 7'd6;
        wr_req_i = 1'b1; wr_addr_i = 7'd8; wr_way_i = 2'd3;
        wr_wdata_i = 64'h8888888888888888; wr_be_i = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t4_wr_gnt_early", wr_gnt_o, 1);
            check("t4_rd_gnt_early", rd_gnt_o, 0);
            check("t4_starve_cnt", dut.starve_cnt, c);
            tick();
        end
        #1;
        check("t4_rd_gnt_starved", rd_gnt_o, 1);
        check("t4_wr_gnt_starved", wr_gnt_o, 0);
        tick();
        rd_req_i = 1'b0;
        check("t4_rvalid", rd_rvalid_o, 1);
        check("t4_set6_way0", rd_rdata_o[0 +: 64], 64'h6666666666666666);
        check("t4_starve_cleared", dut.starve_cnt, 0);
        #1;
        check("t4_wr_gnt_after", wr_gnt_o, 1);
        tick();
        wr_req_i = 1'b0;
        do_read(7'd8);
        check("t4_set8_way3", rd_rdata_o[192 +: 64], 64'h8888888888888888);

        // Test 5: reset in the cycle after a read grant
        do_read(7'd4);
        rst = 1'b1;
        #1;
        check("t5_rvalid_rst", rd_rvalid_o, 0);
        check("t5_rdata_rst", rd_rdata_o, 0);
        tick();
        rst = 1'b0;
        #1;
        check("t5_rvalid_post", rd_rvalid_o, 0);
        check("t5_rdata_post", rd_rdata_o, 0);
        do_read(7'd5);
        check("t5_set5", rd_rdata_o, SET5_FINAL);

        // Same-address conflict: write wins; be=0 write must be a no-op
        rd_req_i = 1'b1; rd_addr_i = 7'd5;
        wr_req_i = 1'b1; wr_addr_i = 7'd5; wr_way_i = 2'd1;
        wr_wdata_i = 64'hDEADBEEFDEADBEEF; wr_be_i = 8'h00;
        #1;
        check("same_addr_rd_gnt", rd_gnt_o, 0);
        check("same_addr_wr_gnt", wr_gnt_o, 1);
        tick();
        rd_req_i = 1'b0; wr_req_i = 1'b0;
        check("same_addr_starve", dut.starve_cnt, 1);
        tick();
        check("starve_holds", dut.starve_cnt, 1);

        // Test 6: back-to-back reads then hold
        do_read(7'd8);
        check("t6_first_way3", rd_rdata_o[192 +: 64], 64'h8888888888888888);
        do_read(7'd5);
        check("t6_second", rd_rdata_o, SET5_FINAL);
        for (int c = 0; c < 8; c++) begin
            if (c == 2) begin
                wr_req_i = 1'b1; wr_addr_i = 7'd5; wr_way_i = 2'd0;
                wr_wdata_i = 64'hFFFFFFFFFFFFFFFF; wr_be_i = 8'hFF;
            end
            tick();
            wr_req_i = 1'b0;
            check("t6_hold_rvalid", rd_rvalid_o, 0);
            check("t6_hold_rdata", rd_rdata_o, SET5_FINAL);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
